// File: rtl/param_sync_fifo.sv
// Parametrised single-clock FIFO with optional first-word-fall-through read,
// almost-full/almost-empty thresholds, occupancy count, flush and sticky error flags.
module param_sync_fifo #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 16,
  parameter int FWFT     = 0,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2
) (
  input  logic                     wclk,
  input  logic                     wrst_n,
  input  logic                     fifo_flush,
  input  logic                     fifo_push,
  input  logic [WIDTH-1:0]         fifo_in,
  input  logic                     fifo_pop,
  output logic [WIDTH-1:0]         fifo_out,
  output logic                     fifo_valid,
  output logic                     fifo_full,
  output logic                     fifo_empty,
  output logic                     fifo_almost_full,
  output logic                     fifo_almost_empty,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     fifo_ovf,
  output logic                     fifo_udf
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];

  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [CW-1:0] count_reg;
  logic [CW-1:0] count_next;
  logic          full_reg;
  logic          empty_reg;
  logic          af_reg;
  logic          ae_reg;
  logic          ovf_reg;
  logic          udf_reg;
  logic          push_ok;
  logic          pop_ok;

  // A full FIFO still accepts a push when the same edge frees a slot.
  always_comb begin
    pop_ok     = fifo_pop & ~empty_reg;
    push_ok    = fifo_push & (~full_reg | pop_ok);
    count_next = count_reg;
    if (push_ok && !pop_ok) begin
      count_next = count_reg + CW'(1);
    end else if (pop_ok && !push_ok) begin
      count_next = count_reg - CW'(1);
    end
  end

  always_ff @(posedge wclk) begin
    if (wrst_n && !fifo_flush && push_ok) begin
      mem[wr_ptr_reg] <= fifo_in;
    end
  end

  always_ff @(posedge wclk) begin
    if (!wrst_n || fifo_flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      full_reg   <= 1'b0;
      empty_reg  <= 1'b1;
      af_reg     <= 1'b0;
      ae_reg     <= 1'b1;
      ovf_reg    <= 1'b0;
      udf_reg    <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (pop_ok) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      count_reg <= count_next;
      full_reg  <= (count_next == CW'(DEPTH));
      empty_reg <= (count_next == '0);
      af_reg    <= (count_next >= CW'(AF_LEVEL));
      ae_reg    <= (count_next <= CW'(AE_LEVEL));
      if (fifo_push && full_reg && !pop_ok) begin
        ovf_reg <= 1'b1;
      end
      if (fifo_pop && empty_reg) begin
        udf_reg <= 1'b1;
      end
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      // Head word is shown combinationally; popping advances to the next entry.
      assign fifo_out   = mem[rd_ptr_reg];
      assign fifo_valid = ~empty_reg;
    end else begin : g_std
      logic [WIDTH-1:0] out_reg;
      logic             valid_reg;

      // Flush clears the valid strobe but keeps the last word on the output.
      always_ff @(posedge wclk) begin
        if (!wrst_n) begin
          out_reg   <= '0;
          valid_reg <= 1'b0;
        end else if (fifo_flush) begin
          valid_reg <= 1'b0;
        end else begin
          valid_reg <= pop_ok;
          if (pop_ok) begin
            out_reg <= mem[rd_ptr_reg];
          end
        end
      end

      assign fifo_out   = out_reg;
      assign fifo_valid = valid_reg;
    end
  endgenerate

  assign fifo_full         = full_reg;
  assign fifo_empty        = empty_reg;
  assign fifo_almost_full  = af_reg;
  assign fifo_almost_empty = ae_reg;
  assign fifo_count        = count_reg;
  assign fifo_ovf          = ovf_reg;
  assign fifo_udf          = udf_reg;

endmodule

// File: tb/tb_param_sync_fifo.sv
// Directed bench: a standard-read FIFO and an FWFT FIFO, both 8 deep x 8 bits.
module tb_param_sync_fifo;

  logic       wclk = 1'b0;
  logic       wrst_n;

  logic       flush, push, pop;
  logic [7:0] din;
  logic [7:0] dout;
  logic       valid, full, empty, af, ae, ovf, udf;
  logic [3:0] count;

  logic       f_flush, f_push, f_pop;
  logic [7:0] f_din;
  logic [7:0] f_dout;
  logic       f_valid, f_full, f_empty, f_af, f_ae, f_ovf, f_udf;
  logic [3:0] f_count;

  int vectors    = 0;
  int miscompares = 0;

  always #5 wclk = ~wclk;

  param_sync_fifo #(.WIDTH(8), .DEPTH(8), .FWFT(0), .AF_LEVEL(6), .AE_LEVEL(2)) dut (
    .wclk(wclk), .wrst_n(wrst_n), .fifo_flush(flush), .fifo_push(push), .fifo_in(din),
    .fifo_pop(pop), .fifo_out(dout), .fifo_valid(valid), .fifo_full(full),
    .fifo_empty(empty), .fifo_almost_full(af), .fifo_almost_empty(ae),
    .fifo_count(count), .fifo_ovf(ovf), .fifo_udf(udf)
  );

  param_sync_fifo #(.WIDTH(8), .DEPTH(8), .FWFT(1), .AF_LEVEL(6), .AE_LEVEL(2)) dut_fwft (
    .wclk(wclk), .wrst_n(wrst_n), .fifo_flush(f_flush), .fifo_push(f_push), .fifo_in(f_din),
    .fifo_pop(f_pop), .fifo_out(f_dout), .fifo_valid(f_valid), .fifo_full(f_full),
    .fifo_empty(f_empty), .fifo_almost_full(f_af), .fifo_almost_empty(f_ae),
    .fifo_count(f_count), .fifo_ovf(f_ovf), .fifo_udf(f_udf)
  );

  task automatic step();
    @(posedge wclk);
    #1;
  endtask

  task automatic load8(input logic [7:0] base);
    for (int i = 0; i < 8; i++) begin
      push = 1'b1;
      din  = 8'(base + 8'(i));
      step();
    end
    push = 1'b0;
  endtask

  task automatic test_reset();
    wrst_n = 1'b0;
    repeat (3) step();
    vectors++;
    if (dout !== 8'h00 || empty !== 1'b1 || ae !== 1'b1 || count !== 4'd0 ||
        ovf !== 1'b0 || udf !== 1'b0 || valid !== 1'b0 || full !== 1'b0 || af !== 1'b0) begin
      $display("FAIL reset: out=%h empty=%b ae=%b count=%0d ovf=%b udf=%b valid=%b full=%b af=%b, need 00 1 1 0 0 0 0 0 0",
               dout, empty, ae, count, ovf, udf, valid, full, af);
      miscompares++;
    end
    vectors++;
    if (f_empty !== 1'b1 || f_valid !== 1'b0 || f_count !== 4'd0) begin
      $display("FAIL reset_fwft: empty=%b valid=%b count=%0d, need 1 0 0", f_empty, f_valid, f_count);
      miscompares++;
    end
    wrst_n = 1'b1;
    step();
  endtask

  task automatic test_fill_drain();
    for (int i = 0; i < 8; i++) begin
      push = 1'b1;
      din  = 8'(8'h10 + 8'(i));
      step();
      vectors++;
      if (count !== 4'(i + 1) || af !== ((i + 1) >= 6) || full !== ((i + 1) == 8) ||
          empty !== 1'b0 || ae !== ((i + 1) <= 2)) begin
        $display("FAIL fill[%0d]: count=%0d af=%b full=%b empty=%b ae=%b, need %0d %b %b 0 %b",
                 i, count, af, full, empty, ae, i + 1, (i + 1) >= 6, (i + 1) == 8, (i + 1) <= 2);
        miscompares++;
      end
    end
    push = 1'b0;
    for (int i = 0; i < 8; i++) begin
      pop = 1'b1;
      step();
      vectors++;
      if (valid !== 1'b1 || dout !== 8'(8'h10 + 8'(i)) || count !== 4'(7 - i) || empty !== (i == 7)) begin
        $display("FAIL drain[%0d]: valid=%b out=%h count=%0d empty=%b, need 1 %h %0d %b",
                 i, valid, dout, count, empty, 8'(8'h10 + 8'(i)), 7 - i, i == 7);
        miscompares++;
      end
    end
    pop = 1'b0;
    step();
    vectors++;
    if (valid !== 1'b0 || empty !== 1'b1 || ae !== 1'b1 || dout !== 8'h17) begin
      $display("FAIL drain_idle: valid=%b empty=%b ae=%b out=%h, need 0 1 1 17", valid, empty, ae, dout);
      miscompares++;
    end
  endtask

  task automatic test_ovf_udf();
    load8(8'h20);
    push = 1'b1;
    din  = 8'hAA;
    step();
    push = 1'b0;
    vectors++;
    if (count !== 4'd8 || ovf !== 1'b1 || full !== 1'b1) begin
      $display("FAIL overflow: count=%0d ovf=%b full=%b, need 8 1 1", count, ovf, full);
      miscompares++;
    end
    for (int i = 0; i < 8; i++) begin
      pop = 1'b1;
      step();
      vectors++;
      if (valid !== 1'b1 || dout !== 8'(8'h20 + 8'(i))) begin
        $display("FAIL ovf_drain[%0d]: valid=%b out=%h, need 1 %h", i, valid, dout, 8'(8'h20 + 8'(i)));
        miscompares++;
      end
    end
    step();
    pop = 1'b0;
    vectors++;
    if (udf !== 1'b1 || valid !== 1'b0 || count !== 4'd0 || dout !== 8'h27 || ovf !== 1'b1) begin
      $display("FAIL underflow: udf=%b valid=%b count=%0d out=%h ovf=%b, need 1 0 0 27 1",
               udf, valid, count, dout, ovf);
      miscompares++;
    end
    flush = 1'b1;
    push  = 1'b1;
    din   = 8'hEE;
    step();
    flush = 1'b0;
    push  = 1'b0;
    vectors++;
    if (ovf !== 1'b0 || udf !== 1'b0 || count !== 4'd0 || empty !== 1'b1) begin
      $display("FAIL flush: ovf=%b udf=%b count=%0d empty=%b, need 0 0 0 1", ovf, udf, count, empty);
      miscompares++;
    end
  endtask

  task automatic test_simultaneous();
    logic [7:0] exp;
    load8(8'h40);
    push = 1'b1;
    pop  = 1'b1;
    din  = 8'h55;
    step();
    push = 1'b0;
    vectors++;
    if (count !== 4'd8 || valid !== 1'b1 || dout !== 8'h40 || ovf !== 1'b0 || full !== 1'b1) begin
      $display("FAIL full_push_pop: count=%0d valid=%b out=%h ovf=%b full=%b, need 8 1 40 0 1",
               count, valid, dout, ovf, full);
      miscompares++;
    end
    for (int i = 0; i < 8; i++) begin
      step();
      exp = (i == 7) ? 8'h55 : 8'(8'h41 + 8'(i));
      vectors++;
      if (valid !== 1'b1 || dout !== exp) begin
        $display("FAIL full_pp_drain[%0d]: valid=%b out=%h, need 1 %h", i, valid, dout, exp);
        miscompares++;
      end
    end
    push = 1'b1;
    din  = 8'h33;
    step();
    push = 1'b0;
    pop  = 1'b0;
    vectors++;
    if (count !== 4'd1 || udf !== 1'b1 || valid !== 1'b0 || empty !== 1'b0) begin
      $display("FAIL empty_push_pop: count=%0d udf=%b valid=%b empty=%b, need 1 1 0 0", count, udf, valid, empty);
      miscompares++;
    end
    pop = 1'b1;
    step();
    pop = 1'b0;
    vectors++;
    if (dout !== 8'h33 || valid !== 1'b1 || count !== 4'd0) begin
      $display("FAIL empty_pp_read: out=%h valid=%b count=%0d, need 33 1 0", dout, valid, count);
      miscompares++;
    end
    flush = 1'b1;
    step();
    flush = 1'b0;
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 3; i++) begin
      push = 1'b1;
      din  = 8'(8'h80 + 8'(i));
      step();
    end
    for (int k = 0; k < 20; k++) begin
      push = 1'b1;
      pop  = 1'b1;
      din  = 8'(8'h83 + 8'(k));
      step();
      vectors++;
      if (valid !== 1'b1 || dout !== 8'(8'h80 + 8'(k)) || count !== 4'd3 ||
          ovf !== 1'b0 || udf !== 1'b0 || full !== 1'b0 || empty !== 1'b0) begin
        $display("FAIL wrap[%0d]: valid=%b out=%h count=%0d ovf=%b udf=%b full=%b empty=%b, need 1 %h 3 0 0 0 0",
                 k, valid, dout, count, ovf, udf, full, empty, 8'(8'h80 + 8'(k)));
        miscompares++;
      end
    end
    push = 1'b0;
    pop  = 1'b0;
  endtask

  task automatic test_fwft();
    f_push = 1'b1;
    f_din  = 8'h01;
    step();
    f_push = 1'b0;
    vectors++;
    if (f_dout !== 8'h01 || f_valid !== 1'b1 || f_count !== 4'd1) begin
      $display("FAIL fwft_first: out=%h valid=%b count=%0d, need 01 1 1", f_dout, f_valid, f_count);
      miscompares++;
    end
    f_push = 1'b1;
    f_din  = 8'h02;
    step();
    f_push = 1'b0;
    vectors++;
    if (f_dout !== 8'h01 || f_count !== 4'd2) begin
      $display("FAIL fwft_second_push: out=%h count=%0d, need 01 2", f_dout, f_count);
      miscompares++;
    end
    f_pop = 1'b1;
    step();
    vectors++;
    if (f_dout !== 8'h02 || f_valid !== 1'b1 || f_count !== 4'd1) begin
      $display("FAIL fwft_pop1: out=%h valid=%b count=%0d, need 02 1 1", f_dout, f_valid, f_count);
      miscompares++;
    end
    step();
    f_pop = 1'b0;
    vectors++;
    if (f_valid !== 1'b0 || f_empty !== 1'b1 || f_udf !== 1'b0) begin
      $display("FAIL fwft_pop2: valid=%b empty=%b udf=%b, need 0 1 0", f_valid, f_empty, f_udf);
      miscompares++;
    end
    f_push = 1'b1;
    f_din  = 8'h07;
    step();
    f_din  = 8'h08;
    step();
    f_push = 1'b0;
    wrst_n = 1'b0;
    step();
    wrst_n = 1'b1;
    vectors++;
    if (f_empty !== 1'b1 || f_valid !== 1'b0 || f_count !== 4'd0) begin
      $display("FAIL fwft_reset: empty=%b valid=%b count=%0d, need 1 0 0", f_empty, f_valid, f_count);
      miscompares++;
    end
  endtask

  initial begin
    wrst_n  = 1'b0;
    flush   = 1'b0;
    push    = 1'b0;
    pop     = 1'b0;
    din     = 8'h00;
    f_flush = 1'b0;
    f_push  = 1'b0;
    f_pop   = 1'b0;
    f_din   = 8'h00;
    test_reset();
    test_fill_drain();
    test_ovf_udf();
    test_simultaneous();
    test_wrap();
    test_fwft();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
